// File: rtl/spi_pkg.sv
// ----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the parametrised SPI master:
//   - FSM state encoding (IDLE/SETUP/XFER/HOLD)
//   - bit positions of the per-transfer mode word
//   - sel_width(): width of an index/counter for a given count, minimum 1
// ----------------------------------------------------------------------------
package spi_pkg;

  // FSM states, kept as plain constants so older tools can consume them.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SETUP = 2'd1;
  localparam state_t ST_XFER  = 2'd2;
  localparam state_t ST_HOLD  = 2'd3;

  // Positions inside the latched mode word.
  localparam int unsigned MODE_CPOL = 0;
  localparam int unsigned MODE_CPHA = 1;
  localparam int unsigned MODE_LSB  = 2;
  localparam int unsigned MODE_W    = 3;

  // Number of bits needed to hold values 0..n-1, never less than 1.
  function automatic int unsigned sel_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// ----------------------------------------------------------------------------
// spi_clk_gen
// SCLK edge timing for the SPI master. While enabled, emits one edge strobe
// every CLK_DIV cycles, alternating leading/trailing, and flags the final
// (2*DATA_W-th) edge. Both counters are held at zero while disabled, so each
// XFER phase starts with an exact CLK_DIV spacing to its first edge.
//
// Ports:
//   clk          system clock
//   m_rst_n      asynchronous active-low reset
//   i_en         high while the master is in XFER
//   o_lead_stb   edge strobe that leaves the idle SCLK level
//   o_trail_stb  edge strobe that returns to the idle SCLK level
//   o_last_edge  the current strobe is the final trailing edge of the word
// ----------------------------------------------------------------------------
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic m_rst_n,
  input  logic i_en,
  output logic o_lead_stb,
  output logic o_trail_stb,
  output logic o_last_edge
);

  localparam int unsigned DIV_W  = sel_width(CLK_DIV);
  localparam int unsigned EDGE_W = sel_width(2 * DATA_W);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

  logic [DIV_W-1:0]  r_div;
  logic [EDGE_W-1:0] r_edge;
  logic              w_tick;

  assign w_tick = i_en && (r_div == DIV_LAST);

  always_ff @(posedge clk or negedge m_rst_n) begin
    if (!m_rst_n) begin
      r_div  <= '0;
      r_edge <= '0;
    end else if (!i_en) begin
      r_div  <= '0;
      r_edge <= '0;
    end else if (w_tick) begin
      r_div  <= '0;
      r_edge <= r_edge + EDGE_W'(1);
    end else begin
      r_div  <= r_div + DIV_W'(1);
    end
  end

  // Even edge numbers are leading edges, odd ones trailing.
  assign o_lead_stb  = w_tick && !r_edge[0];
  assign o_trail_stb = w_tick && r_edge[0];
  assign o_last_edge = w_tick && (r_edge == EDGE_LAST);

endmodule

// File: rtl/spi_master_param.sv
// ----------------------------------------------------------------------------
// spi_master_param
// Parametrised full-duplex SPI master with per-transfer CPOL/CPHA/bit order
// and a start/ready command handshake. One word per transfer, one-hot
// active-low slave select.
//
// Ports:
//   clk, m_rst_n         system clock, asynchronous active-low reset
//   start / ready        request, accepted when start && ready (IDLE only)
//   tx_data, slave_sel   word and target, sampled at acceptance
//   cpol, cpha,
//   lsb_first            mode bits, sampled at acceptance
//   rx_data / rx_valid   received word, one-cycle valid pulse
//   sel_err              one-cycle pulse for an out-of-range slave_sel
//   busy                 high from acceptance until back in IDLE
//   sclk, mosi, miso     SPI serial pins
//   ss_n                 one-hot active-low slave selects
// ----------------------------------------------------------------------------
module spi_master_param
  import spi_pkg::*;
#(
  parameter  int unsigned DATA_W     = 8,
  parameter  int unsigned NUM_SLAVES = 4,
  parameter  int unsigned CLK_DIV    = 4,
  localparam int unsigned SEL_W      = sel_width(NUM_SLAVES)
) (
  input  logic                  clk,
  input  logic                  m_rst_n,
  input  logic                  start,
  output logic                  ready,
  input  logic [DATA_W-1:0]     tx_data,
  input  logic [SEL_W-1:0]      slave_sel,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  output logic [DATA_W-1:0]     rx_data,
  output logic                  rx_valid,
  output logic                  sel_err,
  output logic                  busy,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic [NUM_SLAVES-1:0] ss_n
);

  localparam int unsigned       CNT_W    = sel_width(CLK_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [SEL_W:0]    NUM_SL   = (SEL_W + 1)'(NUM_SLAVES);

  // Next bit to put on mosi for the chosen order.
  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  // Discard the bit just sent.
  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w,
                                                   input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  // Insert a received bit so the finished word keeps natural bit weights.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w,
                                                  input logic b, input logic lsb);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [MODE_W-1:0]       r_cfg;
  logic [DATA_W-1:0]       r_tx;
  logic [DATA_W-1:0]       r_rx;
  logic [DATA_W-1:0]       r_rx_data;
  logic                    r_rx_valid;
  logic                    r_sel_err;
  logic                    r_sclk;
  logic                    r_mosi;
  logic [NUM_SLAVES-1:0]   r_ss_n;

  logic                    w_idle;
  logic                    w_sel_ok;
  logic                    w_accept;
  logic                    w_reject;
  logic                    w_cnt_done;
  logic [NUM_SLAVES-1:0]   w_sel_dec;
  logic                    w_lead;
  logic                    w_trail;
  logic                    w_last;
  logic                    w_drive;
  logic                    w_sample;
  logic                    w_cpha;
  logic                    w_lsb;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_sel_ok   = ({1'b0, slave_sel} < NUM_SL);
  assign w_accept   = w_idle && start && w_sel_ok;
  assign w_reject   = w_idle && start && !w_sel_ok;
  assign w_cnt_done = (r_cnt == CNT_LAST);
  assign w_cpha     = r_cfg[MODE_CPHA];
  assign w_lsb      = r_cfg[MODE_LSB];

  // cpha=0 drives on trailing edges (first bit already out from SETUP, no
  // shift after the final edge); cpha=1 drives on leading edges.
  assign w_drive  = w_cpha ? w_lead : (w_trail && !w_last);
  assign w_sample = w_cpha ? w_trail : w_lead;

  always_comb begin
    w_sel_dec = '1;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (slave_sel == SEL_W'(i)) begin
        w_sel_dec[i] = 1'b0;
      end
    end
  end

  spi_clk_gen #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk         (clk),
    .m_rst_n     (m_rst_n),
    .i_en        (r_state == ST_XFER),
    .o_lead_stb  (w_lead),
    .o_trail_stb (w_trail),
    .o_last_edge (w_last)
  );

  always_ff @(posedge clk or negedge m_rst_n) begin
    if (!m_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_cfg      <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_sel_err  <= 1'b0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_ss_n     <= '1;
    end else begin
      r_rx_valid <= 1'b0;
      r_sel_err  <= w_reject;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state          <= ST_SETUP;
            r_cnt            <= '0;
            r_cfg[MODE_CPOL] <= cpol;
            r_cfg[MODE_CPHA] <= cpha;
            r_cfg[MODE_LSB]  <= lsb_first;
            r_sclk           <= cpol;
            r_ss_n           <= w_sel_dec;
            r_rx             <= '0;
            if (!cpha) begin
              r_mosi <= first_bit(tx_data, lsb_first);
              r_tx   <= shift_out(tx_data, lsb_first);
            end else begin
              r_mosi <= 1'b0;
              r_tx   <= tx_data;
            end
          end
        end
        ST_SETUP: begin
          if (w_cnt_done) begin
            r_state <= ST_XFER;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_XFER: begin
          if (w_lead || w_trail) begin
            r_sclk <= ~r_sclk;
          end
          if (w_drive) begin
            r_mosi <= first_bit(r_tx, w_lsb);
            r_tx   <= shift_out(r_tx, w_lsb);
          end
          if (w_sample) begin
            r_rx <= shift_in(r_rx, miso, w_lsb);
          end
          if (w_last) begin
            r_state <= ST_HOLD;
            r_cnt   <= '0;
          end
        end
        ST_HOLD: begin
          if (w_cnt_done) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_rx_data  <= r_rx;
            r_rx_valid <= 1'b1;
            r_ss_n     <= '1;
            r_mosi     <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready    = w_idle;
  assign busy     = !w_idle;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign sel_err  = r_sel_err;
  assign sclk     = r_sclk;
  assign mosi     = r_mosi;
  assign ss_n     = r_ss_n;

endmodule

// File: tb/tb_spi_master_param.sv
// ----------------------------------------------------------------------------
// tb_spi_master_param
// Directed bench for spi_master_param. Three instances:
//   A: defaults (8-bit, 4 slaves, CLK_DIV=4) with an edge-driven slave model
//   B: NUM_SLAVES=3, CLK_DIV=2, miso tied high (select range checks)
//   C: DATA_W=16, CLK_DIV=1, miso looped back from mosi
// ----------------------------------------------------------------------------
module tb_spi_master_param;

  logic clk;
  logic m_rst_n;

  int n_total;
  int n_bad;

  // ---------------- instance A ----------------
  logic       start_a, ready_a, cpol_a, cpha_a, lsb_a;
  logic [7:0] tx_a, rx_a;
  logic [1:0] sel_a;
  logic       rxv_a, selerr_a, busy_a, sclk_a, mosi_a, miso_a;
  logic [3:0] ss_a;

  spi_master_param u_dut_a (
    .clk       (clk),
    .m_rst_n   (m_rst_n),
    .start     (start_a),
    .ready     (ready_a),
    .tx_data   (tx_a),
    .slave_sel (sel_a),
    .cpol      (cpol_a),
    .cpha      (cpha_a),
    .lsb_first (lsb_a),
    .rx_data   (rx_a),
    .rx_valid  (rxv_a),
    .sel_err   (selerr_a),
    .busy      (busy_a),
    .sclk      (sclk_a),
    .mosi      (mosi_a),
    .miso      (miso_a),
    .ss_n      (ss_a)
  );

  // ---------------- instance B ----------------
  logic       start_b, ready_b;
  logic [7:0] tx_b, rx_b;
  logic [1:0] sel_b;
  logic       rxv_b, selerr_b, busy_b, sclk_b, mosi_b;
  logic [2:0] ss_b;

  spi_master_param #(
    .DATA_W     (8),
    .NUM_SLAVES (3),
    .CLK_DIV    (2)
  ) u_dut_b (
    .clk       (clk),
    .m_rst_n   (m_rst_n),
    .start     (start_b),
    .ready     (ready_b),
    .tx_data   (tx_b),
    .slave_sel (sel_b),
    .cpol      (1'b0),
    .cpha      (1'b0),
    .lsb_first (1'b0),
    .rx_data   (rx_b),
    .rx_valid  (rxv_b),
    .sel_err   (selerr_b),
    .busy      (busy_b),
    .sclk      (sclk_b),
    .mosi      (mosi_b),
    .miso      (1'b1),
    .ss_n      (ss_b)
  );

  // ---------------- instance C ----------------
  logic        start_c, ready_c;
  logic [15:0] tx_c, rx_c;
  logic        rxv_c, selerr_c, busy_c, sclk_c, mosi_c;
  logic [3:0]  ss_c;

  spi_master_param #(
    .DATA_W     (16),
    .NUM_SLAVES (4),
    .CLK_DIV    (1)
  ) u_dut_c (
    .clk       (clk),
    .m_rst_n   (m_rst_n),
    .start     (start_c),
    .ready     (ready_c),
    .tx_data   (tx_c),
    .slave_sel (2'd0),
    .cpol      (1'b0),
    .cpha      (1'b1),
    .lsb_first (1'b0),
    .rx_data   (rx_c),
    .rx_valid  (rxv_c),
    .sel_err   (selerr_c),
    .busy      (busy_c),
    .sclk      (sclk_c),
    .mosi      (mosi_c),
    .miso      (mosi_c),
    .ss_n      (ss_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- slave model for A ----------------
  // Behaves like an SPI slave watching sclk: drives miso and captures mosi on
  // the edges its configured mode dictates.
  logic [7:0] s_word, s_seq, s_got;
  int         s_sel;
  logic       s_cpol, s_cpha, s_lsb;

  initial begin
    logic started, prev, lead;
    int   n_tx, n_rx;
    miso_a = 1'b0;
    started = 1'b0;
    prev = 1'b0;
    n_tx = 0;
    n_rx = 0;
    forever begin
      @(negedge clk);
      if (!m_rst_n || ss_a[s_sel]) begin
        started = 1'b0;
        prev = sclk_a;
      end else if (!started) begin
        started = 1'b1;
        prev = sclk_a;
        n_tx = 0;
        n_rx = 0;
        s_seq = '0;
        s_got = '0;
        if (!s_cpha) begin
          miso_a = s_lsb ? s_word[0] : s_word[7];
          n_tx = 1;
        end
      end else if (sclk_a != prev) begin
        lead = (prev == s_cpol);
        prev = sclk_a;
        if (lead != s_cpha) begin
          if (n_rx < 8) begin
            s_seq = {s_seq[6:0], mosi_a};
            s_got[s_lsb ? n_rx : 7 - n_rx] = mosi_a;
            n_rx++;
          end
        end else if (n_tx < 8) begin
          miso_a = s_lsb ? s_word[n_tx] : s_word[7 - n_tx];
          n_tx++;
        end
      end
    end
  end

  // Called at the first negedge with ss_n low; returns at the negedge where
  // ss_n is back high (or after a cycle budget).
  task automatic wait_end_a(output int low, output int pulses, output logic [7:0] rxd);
    low = 1;
    pulses = 0;
    rxd = '0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rxv_a) begin
        pulses++;
        rxd = rx_a;
      end
      if (ss_a == 4'hF) return;
      low++;
    end
  endtask

  task automatic run_a(input string tag, input logic [7:0] tx, input logic [1:0] sel,
                       input logic cpol, input logic cpha, input logic lsb,
                       input logic [7:0] sword, input logic [3:0] exp_ss,
                       input logic [7:0] exp_seq);
    int         low, pulses;
    logic [7:0] rxd;
    s_word = sword;
    s_sel = int'(sel);
    s_cpol = cpol;
    s_cpha = cpha;
    s_lsb = lsb;
    tx_a = tx;
    sel_a = sel;
    cpol_a = cpol;
    cpha_a = cpha;
    lsb_a = lsb;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    // Scramble the request inputs: they must not affect the running transfer.
    tx_a = ~tx;
    cpol_a = ~cpol;
    cpha_a = ~cpha;
    lsb_a = ~lsb;
    sel_a = sel + 2'd1;
    check_eq({tag, "_busy"}, 32'(busy_a), 32'h1);
    check_eq({tag, "_ready"}, 32'(ready_a), 32'h0);
    check_eq({tag, "_ss"}, 32'(ss_a), 32'(exp_ss));
    check_eq({tag, "_sclk_setup"}, 32'(sclk_a), 32'(cpol));
    wait_end_a(low, pulses, rxd);
    check_eq({tag, "_ss_low"}, 32'(low), 32'd72);
    check_eq({tag, "_rxv_cnt"}, 32'(pulses), 32'd1);
    check_eq({tag, "_rx"}, 32'(rxd), 32'(sword));
    check_eq({tag, "_mosi_seq"}, 32'(s_seq), 32'(exp_seq));
    check_eq({tag, "_mosi_word"}, 32'(s_got), 32'(tx));
    check_eq({tag, "_ready_end"}, 32'(ready_a), 32'h1);
    @(negedge clk);
    check_eq({tag, "_rxv_off"}, 32'(rxv_a), 32'h0);
    check_eq({tag, "_sclk_idle"}, 32'(sclk_a), 32'(cpol));
    check_eq({tag, "_mosi_idle"}, 32'(mosi_a), 32'h0);
  endtask

  initial begin
    int         low, pulses, edges;
    logic       prev;
    logic [7:0] rxd;

    n_total = 0;
    n_bad = 0;
    m_rst_n = 1'b0;
    start_a = 1'b0; tx_a = '0; sel_a = '0; cpol_a = 1'b0; cpha_a = 1'b0; lsb_a = 1'b0;
    start_b = 1'b0; tx_b = '0; sel_b = '0;
    start_c = 1'b0; tx_c = '0;
    s_word = '0; s_sel = 0; s_cpol = 1'b0; s_cpha = 1'b0; s_lsb = 1'b0;
    s_seq = '0; s_got = '0;

    repeat (3) @(negedge clk);
    // Reset values
    check_eq("rst_ready", 32'(ready_a), 32'h1);
    check_eq("rst_busy", 32'(busy_a), 32'h0);
    check_eq("rst_rx", 32'(rx_a), 32'h0);
    check_eq("rst_rxv", 32'(rxv_a), 32'h0);
    check_eq("rst_selerr", 32'(selerr_a), 32'h0);
    check_eq("rst_sclk", 32'(sclk_a), 32'h0);
    check_eq("rst_mosi", 32'(mosi_a), 32'h0);
    check_eq("rst_ss", 32'(ss_a), 32'hF);
    check_eq("rst_ss_b", 32'(ss_b), 32'h7);
    check_eq("rst_ss_c", 32'(ss_c), 32'hF);
    m_rst_n = 1'b1;
    @(negedge clk);

    // Mode 0, MSB first
    run_a("m0", 8'hA5, 2'd0, 1'b0, 1'b0, 1'b0, 8'h57, 4'b1110, 8'hA5);
    // Mode 3, LSB first, slave 2; 0x3C bit-reversed is 0x3C
    run_a("m3", 8'h3C, 2'd2, 1'b1, 1'b1, 1'b1, 8'h96, 4'b1011, 8'h3C);

    // Back-to-back with start held high
    s_word = 8'h11; s_sel = 1; s_cpol = 1'b0; s_cpha = 1'b0; s_lsb = 1'b0;
    tx_a = 8'h01; sel_a = 2'd1; cpol_a = 1'b0; cpha_a = 1'b0; lsb_a = 1'b0;
    start_a = 1'b1;
    @(negedge clk);
    tx_a = 8'h80;
    check_eq("b2b_ss1", 32'(ss_a), 32'hD);
    wait_end_a(low, pulses, rxd);
    check_eq("b2b_low1", 32'(low), 32'd72);
    check_eq("b2b_rxv1", 32'(pulses), 32'd1);
    check_eq("b2b_rx1", 32'(rxd), 32'h11);
    check_eq("b2b_word1", 32'(s_got), 32'h01);
    check_eq("b2b_ready1", 32'(ready_a), 32'h1);
    s_word = 8'h22;
    @(negedge clk);
    start_a = 1'b0;
    check_eq("b2b_ss2", 32'(ss_a), 32'hD);
    check_eq("b2b_busy2", 32'(busy_a), 32'h1);
    wait_end_a(low, pulses, rxd);
    check_eq("b2b_low2", 32'(low), 32'd72);
    check_eq("b2b_rxv2", 32'(pulses), 32'd1);
    check_eq("b2b_rx2", 32'(rxd), 32'h22);
    check_eq("b2b_word2", 32'(s_got), 32'h80);
    @(negedge clk);
    check_eq("b2b_idle", 32'(ss_a), 32'hF);

    // Reset after 5 SCLK edges
    s_word = 8'h99; s_sel = 3; s_cpol = 1'b0; s_cpha = 1'b0; s_lsb = 1'b0;
    tx_a = 8'h5A; sel_a = 2'd3; cpol_a = 1'b0; cpha_a = 1'b0; lsb_a = 1'b0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    prev = sclk_a;
    edges = 0;
    for (int i = 0; i < 200 && edges < 5; i++) begin
      @(negedge clk);
      if (sclk_a != prev) begin
        edges++;
        prev = sclk_a;
      end
    end
    check_eq("mr_edges", 32'(edges), 32'd5);
    check_eq("mr_pre_ss", 32'(ss_a), 32'h7);
    check_eq("mr_pre_sclk", 32'(sclk_a), 32'h1);
    m_rst_n = 1'b0;
    #1;
    check_eq("mr_ss", 32'(ss_a), 32'hF);
    check_eq("mr_sclk", 32'(sclk_a), 32'h0);
    check_eq("mr_mosi", 32'(mosi_a), 32'h0);
    check_eq("mr_busy", 32'(busy_a), 32'h0);
    check_eq("mr_rxv", 32'(rxv_a), 32'h0);
    check_eq("mr_rx", 32'(rx_a), 32'h0);
    @(negedge clk);
    m_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("mr_quiet_rxv", 32'(rxv_a), 32'h0);
      check_eq("mr_quiet_ss", 32'(ss_a), 32'hF);
    end
    // Mode 1 after reset
    run_a("m1", 8'hC3, 2'd0, 1'b0, 1'b1, 1'b0, 8'h3A, 4'b1110, 8'hC3);

    // Instance B: out-of-range select, then the top valid index
    sel_b = 2'd3; tx_b = 8'h55; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check_eq("b_selerr", 32'(selerr_b), 32'h1);
    check_eq("b_rej_ss", 32'(ss_b), 32'h7);
    check_eq("b_rej_busy", 32'(busy_b), 32'h0);
    check_eq("b_rej_ready", 32'(ready_b), 32'h1);
    check_eq("b_rej_sclk", 32'(sclk_b), 32'h0);
    @(negedge clk);
    check_eq("b_selerr_off", 32'(selerr_b), 32'h0);
    check_eq("b_rej_ss2", 32'(ss_b), 32'h7);
    check_eq("b_rej_busy2", 32'(busy_b), 32'h0);
    sel_b = 2'd2; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check_eq("b_ss", 32'(ss_b), 32'h3);
    check_eq("b_ok_selerr", 32'(selerr_b), 32'h0);
    low = 1;
    for (int i = 0; i < 500 && ss_b != 3'h7; i++) begin
      @(negedge clk);
      if (ss_b != 3'h7) low++;
    end
    check_eq("b_low", 32'(low), 32'd36);
    check_eq("b_rxv", 32'(rxv_b), 32'h1);
    check_eq("b_rx", 32'(rx_b), 32'hFF);
    check_eq("b_mosi_idle", 32'(mosi_b), 32'h0);

    // Instance C: 16-bit, CLK_DIV=1, mode 1, loopback
    tx_c = 16'hBEEF; start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    tx_c = 16'h0000;
    check_eq("c_ss", 32'(ss_c), 32'hE);
    check_eq("c_busy", 32'(busy_c), 32'h1);
    check_eq("c_ready", 32'(ready_c), 32'h0);
    low = 1;
    for (int i = 0; i < 500 && ss_c != 4'hF; i++) begin
      @(negedge clk);
      if (ss_c != 4'hF) low++;
    end
    check_eq("c_low", 32'(low), 32'd34);
    check_eq("c_rxv", 32'(rxv_c), 32'h1);
    check_eq("c_rx", 32'(rx_c), 32'hBEEF);
    check_eq("c_sclk_idle", 32'(sclk_c), 32'h0);
    check_eq("c_selerr", 32'(selerr_c), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_master_param.md
# spi_master_param

Parametrised full-duplex SPI master, the next generation of the SPI master in the SPI system. It generalises the fixed 8-bit, 4-slave, mode-0 master to configurable word width, slave count and SCLK divider. It adds per-transfer CPOL/CPHA/bit-order selection and a valid/ready command handshake. It sits between a host-side register/control block and the SPI pins, driving one-hot active-low slave selects.

## Interface
Parameters:
- DATA_W, 8, bits per transfer word (≥2)
- NUM_SLAVES, 4, number of slave-select lines (≥1)
- CLK_DIV, 4, clk cycles per SCLK half-period (≥1)

Ports:
- clk  in  1  system clock; all logic on rising edge
- m_rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  transfer request; accepted when start && ready
- ready  out  1  high only in IDLE
- tx_data  in  DATA_W  word to shift out, sampled at acceptance
- slave_sel  in  $clog2(NUM_SLAVES) (min 1)  target slave index, sampled at acceptance
- cpol, cpha, lsb_first  in  1 each  mode bits, sampled at acceptance
- rx_data  out  DATA_W  last received word; held until next rx_valid
- rx_valid  out  1  one-cycle pulse, rx_data updated
- sel_err  out  1  one-cycle pulse, request rejected (slave_sel ≥ NUM_SLAVES)
- busy  out  1  high from acceptance until return to IDLE
- sclk  out  1  SPI clock
- mosi  out  1  serial data out
- miso  in  1  serial data in
- ss_n  out  NUM_SLAVES  one-hot-low slave selects

## Operation
- States: IDLE → SETUP → XFER → HOLD → IDLE.
- IDLE: ready=1, busy=0. On start && slave_sel < NUM_SLAVES: latch tx_data, slave_sel, cpol, cpha, lsb_first into the shift register/config; go to SETUP. On start with out-of-range slave_sel: stay IDLE, pulse sel_err next cycle, no pin activity.
- SETUP: ss_n[sel]=0 for CLK_DIV cycles, sclk=cpol. If cpha=0, mosi drives the first bit from entry into SETUP.
- XFER: 2·DATA_W SCLK edges, one every CLK_DIV cycles. The leading edge (first of each pair) leaves the idle level; the trailing edge returns to it.
- cpha=0: sample miso on the leading edge, shift mosi on the trailing edge (no shift after the last trailing edge).
- cpha=1: shift mosi on the leading edge (first leading edge drives bit 0 of the order), sample on the trailing edge.
- Bit order: lsb_first=0 sends/receives MSB first; lsb_first=1 sends/receives LSB first. rx_data keeps its natural bit weights either way.
- HOLD: sclk=cpol, ss_n[sel] held low for CLK_DIV cycles. On the last HOLD cycle, the FSM registers rx_data, pulses rx_valid, deasserts ss_n and returns to IDLE.
- start while busy is ignored and not queued.
- Mode inputs changing mid-transfer have no effect.

## Timing
- Reset values: ready=1, busy=0, rx_data=0, rx_valid=0, sel_err=0, sclk=0, mosi=0, ss_n=all ones. The state is IDLE.
- Reset asserted mid-transfer forces the reset values immediately, asynchronously, with no rx_valid. The first transfer after reset release needs a fresh start.
- In IDLE, sclk holds the cpol of the last accepted transfer (0 after reset) and mosi=0.
- Acceptance edge: busy=1, ready=0 and ss_n[sel]=0 on the following cycle.
- ss_n low duration: CLK_DIV·(2·DATA_W+2) cycles. For the defaults this is 72.
- rx_valid goes high in the cycle ss_n returns high. ready returns to 1 in that same cycle, so the next start is accepted back-to-back.
- The divider counter restarts at 0 on every state entry, so edge spacing is exact for CLK_DIV=1.

## Structure
- Package spi_pkg holds:
  - the state enum (IDLE/SETUP/XFER/HOLD)
  - mode bit position constants
  - the helper function computing the slave_sel width
- One sub-module, spi_clk_gen:
  - CLK_DIV counter plus edge counter
  - outputs lead_stb, trail_stb and last_edge, enabled only in XFER
- The top level holds the FSM, the shift registers and the ss_n decode.

## Test plan
- Mode 0, defaults: tx_data=0xA5, slave model returns 0x57 MSB-first → mosi 10100101, rx_data=0x57 with one rx_valid pulse, ss_n=4'b1110 for exactly 72 cycles.
- Mode 3, lsb_first=1, slave_sel=2: tx_data=0x3C → idle sclk=1, mosi bit sequence 00111100 reversed (LSB first), ss_n=4'b1011, rx_data matches slave word.
- Back-to-back: start held high for two words 0x01, 0x80 → second start ignored during busy, accepted the cycle ready returns; two rx_valid pulses, ss_n high one cycle between transfers.
- NUM_SLAVES=3, slave_sel=3 → sel_err pulse one cycle after request, ss_n stays 3'b111, busy stays 0.
- Reset mid-XFER (after 5 SCLK edges) → ss_n all ones, sclk=0, mosi=0 immediately, no rx_valid; the next transfer completes correctly.
- DATA_W=16, CLK_DIV=1, mode 1: tx_data=0xBEEF, loopback miso=mosi → rx_data=0xBEEF, ss_n low 34 cycles.
